// File: rtl/multicycle_control_fsm.sv
// Sequencer for the shared-ALU, shared-memory multicycle MIPS datapath; memory accesses stall on mem_ready.
// Optional MCFSM_PERF_COUNTERS_EN adds instr_count/stall_count outputs.
module multicycle_control_fsm #(
  parameter int OP_WIDTH = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] OP,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCEn,
  output logic [1:0]          PCSource,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
`ifdef MCFSM_PERF_COUNTERS_EN
  ,
  output logic [31:0]         instr_count,
  output logic [31:0]         stall_count
`endif
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB = 4'd5,  MEMWR  = 4'd6,  EXE_R  = 4'd7,
    R_WB   = 4'd8,  EXE_I = 4'd9,  I_WB   = 4'd10, BRANCH = 4'd11,
    JUMP   = 4'd12, HALT  = 4'd13
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'h00);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'h23);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'h2B);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'h08);
  localparam logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(6'h0D);
  localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(6'h0F);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'h04);
  localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(6'h05);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'h02);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(3'b111);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (OP)
          OP_RTYPE:               state_d = EXE_R;
          OP_LW, OP_SW:           state_d = MEMADR;
          OP_ADDI, OP_ORI, OP_LUI: state_d = EXE_I;
          OP_BEQ, OP_BNE:         state_d = BRANCH;
          OP_J:                   state_d = JUMP;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (OP == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWR:  if (mem_ready) state_d = FETCH;
      MEMWB:  state_d = FETCH;
      EXE_R:  state_d = R_WB;
      R_WB:   state_d = FETCH;
      EXE_I:  state_d = I_WB;
      I_WB:   state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // FETCH and BRANCH gate their PC/IR enables combinationally on inputs.
  always_comb begin
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCEn     = 1'b0;
    PCSource = 2'b00;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      EXE_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FN;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      EXE_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OP == OP_ORI)      ALUOp = ALU_OR;
        else if (OP == OP_LUI) ALUOp = ALU_LUI;
        else                   ALUOp = ALU_ADD;
      end
      I_WB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCEn     = ((OP == OP_BEQ) && Zero) || ((OP == OP_BNE) && !Zero);
      end
      JUMP: begin
        PCSource = 2'b10;
        PCEn     = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state_dbg  = state_q;

`ifdef MCFSM_PERF_COUNTERS_EN
  logic [31:0] instr_q, stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if ((state_q == FETCH) && mem_ready) instr_q <= instr_q + 32'd1;
      if (mem_req && !mem_ready)           stall_q <= stall_q + 32'd1;
    end
  end

  assign instr_count = instr_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm: per-cycle expected state/controls via a scoreboard queue.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mem_req, mem_write, iord, irwrite, pcen;
    logic [1:0] pcsource;
    logic       regdst, regwrite, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic       zero, rdy;
    logic [3:0] st;
    ctrl_t      c;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    ctrl_t      c;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       Zero, mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, PCEn, RegDst, RegWrite, MemtoReg, ALUSrcA;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic       illegal_op;
  logic [3:0] state_dbg;
`ifdef MCFSM_PERF_COUNTERS_EN
  logic [31:0] instr_count, stall_count;
`endif

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSource(PCSource), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
`ifdef MCFSM_PERF_COUNTERS_EN
    , .instr_count(instr_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  ctrl_t act;
  assign act = '{mem_req, MemWrite, IorD, IRWrite, PCEn, PCSource, RegDst, RegWrite,
                 MemtoReg, ALUSrcA, ALUSrcB, ALUOp};

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic ctrl_t mk(input logic req, wr, iord, irw, pcen, input logic [1:0] pcs,
                               input logic rdst, rw, m2r, srca, input logic [1:0] srcb,
                               input logic [2:0] aluop);
    ctrl_t c;
    c = '{req, wr, iord, irw, pcen, pcs, rdst, rw, m2r, srca, srcb, aluop};
    return c;
  endfunction

  task automatic add(input logic [5:0] op, input logic zero, input logic rdy,
                     input logic [3:0] st, input ctrl_t c, input logic ill);
    vec_t v;
    v.op = op; v.zero = zero; v.rdy = rdy; v.st = st; v.c = c; v.ill = ill;
    tbl.push_back(v);
  endtask

  // One row per cycle: drive on the falling edge, compare 2 time units later.
  task automatic run_table(input string tag);
    exp_t e;
    foreach (tbl[i]) begin
      @(negedge clk);
      OP = tbl[i].op; Zero = tbl[i].zero; mem_ready = tbl[i].rdy;
      e.st = tbl[i].st; e.c = tbl[i].c; e.ill = tbl[i].ill;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      chk($sformatf("%s[%0d].state", tag, i), 32'(state_dbg), 32'(e.st));
      chk($sformatf("%s[%0d].ctrl", tag, i), 32'(act), 32'(e.c));
      chk($sformatf("%s[%0d].illegal", tag, i), 32'(illegal_op), 32'(e.ill));
    end
    tbl.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  ctrl_t c0, cF1, cF0, cD, cMA, cMR, cMW, cWB, cER, cRW, cIW, cJ;

  initial begin
    c0  = '0;
    cF1 = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,3'b000);
    cF0 = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,3'b000);
    cD  = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b000);
    cMA = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b000);
    cMR = mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000);
    cMW = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,3'b000);
    cWB = mk(0,0,0,0,0,2'b00,0,1,1,0,2'b00,3'b000);
    cER = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,3'b111);
    cRW = mk(0,0,0,0,0,2'b00,1,1,0,0,2'b00,3'b000);
    cIW = mk(0,0,0,0,0,2'b00,0,1,0,0,2'b00,3'b000);
    cJ  = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,3'b000);

    reset = 1'b0; OP = '0; Zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset.state", 32'(state_dbg), 32'd0);
    chk("reset.ctrl", 32'(act), 32'(c0));
    chk("reset.illegal", 32'(illegal_op), 32'd0);
    release_reset();

    add(6'h00,0,1, 4'd0, c0, 0);
    add(6'h00,0,0, 4'd1, cF0, 0);          // fetch stall: no IR/PC load
    add(6'h00,0,1, 4'd1, cF1, 0);
    add(6'h00,0,1, 4'd2, cD, 0);
    add(6'h00,0,1, 4'd7, cER, 0);
    add(6'h00,0,1, 4'd8, cRW, 0);
    add(6'h23,0,1, 4'd1, cF1, 0);
    add(6'h23,0,0, 4'd2, cD, 0);           // mem_ready low in DECODE ignored
    add(6'h23,0,0, 4'd3, cMA, 0);
    add(6'h23,0,0, 4'd4, cMR, 0);
    add(6'h23,0,0, 4'd4, cMR, 0);
    add(6'h23,0,0, 4'd4, cMR, 0);
    add(6'h23,0,1, 4'd4, cMR, 0);
    add(6'h23,0,0, 4'd5, cWB, 0);
    add(6'h2B,0,1, 4'd1, cF1, 0);
    add(6'h2B,0,1, 4'd2, cD, 0);
    add(6'h2B,0,1, 4'd3, cMA, 0);
    add(6'h2B,0,1, 4'd6, cMW, 0);
    add(6'h05,0,1, 4'd1, cF1, 0);
    add(6'h05,0,1, 4'd2, cD, 0);
    add(6'h05,0,1, 4'd11, mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,3'b001), 0);
    add(6'h05,1,1, 4'd1, cF1, 0);
    add(6'h05,1,1, 4'd2, cD, 0);
    add(6'h05,1,1, 4'd11, mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,3'b001), 0);
    add(6'h04,1,1, 4'd1, cF1, 0);
    add(6'h04,1,1, 4'd2, cD, 0);
    add(6'h04,1,1, 4'd11, mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,3'b001), 0);
    add(6'h04,0,1, 4'd1, cF1, 0);
    add(6'h04,0,1, 4'd2, cD, 0);
    add(6'h04,0,1, 4'd11, mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,3'b001), 0);
    add(6'h0D,0,1, 4'd1, cF1, 0);
    add(6'h0D,0,1, 4'd2, cD, 0);
    add(6'h0D,0,1, 4'd9, mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010), 0);
    add(6'h0D,0,1, 4'd10, cIW, 0);
    add(6'h0F,0,1, 4'd1, cF1, 0);
    add(6'h0F,0,1, 4'd2, cD, 0);
    add(6'h0F,0,1, 4'd9, mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b011), 0);
    add(6'h0F,0,1, 4'd10, cIW, 0);
    add(6'h08,0,1, 4'd1, cF1, 0);
    add(6'h08,0,1, 4'd2, cD, 0);
    add(6'h08,0,1, 4'd9, mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b000), 0);
    add(6'h08,0,1, 4'd10, cIW, 0);
    add(6'h02,0,1, 4'd1, cF1, 0);
    add(6'h02,0,1, 4'd2, cD, 0);
    add(6'h02,0,1, 4'd12, cJ, 0);
    add(6'h3F,0,1, 4'd1, cF1, 0);
    add(6'h3F,0,1, 4'd2, cD, 0);
    add(6'h3F,0,1, 4'd13, c0, 1);
    add(6'h00,0,1, 4'd13, c0, 1);
    add(6'h23,1,0, 4'd13, c0, 1);
    run_table("main");

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("halt_reset.state", 32'(state_dbg), 32'd0);
    chk("halt_reset.illegal", 32'(illegal_op), 32'd0);
    release_reset();

    add(6'h2B,0,1, 4'd0, c0, 0);
    add(6'h2B,0,1, 4'd1, cF1, 0);
    add(6'h2B,0,1, 4'd2, cD, 0);
    add(6'h2B,0,0, 4'd3, cMA, 0);
    add(6'h2B,0,0, 4'd6, cMW, 0);
    run_table("sw_abort");
    #1 reset = 1'b0;                       // asynchronous, away from any edge
    #1;
    chk("abort.state", 32'(state_dbg), 32'd0);
    chk("abort.MemWrite", 32'(MemWrite), 32'd0);
    chk("abort.mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("abort.hold_state", 32'(state_dbg), 32'd0);

`ifdef MCFSM_PERF_COUNTERS_EN
    chk("perf.instr_reset", instr_count, 32'd0);
    chk("perf.stall_reset", stall_count, 32'd0);
    release_reset();
    add(6'h23,0,1, 4'd0, c0, 0);
    for (int k = 0; k < 3; k++) begin
      add(6'h23,0,1, 4'd1, cF1, 0);
      add(6'h23,0,1, 4'd2, cD, 0);
      add(6'h23,0,1, 4'd3, cMA, 0);
      add(6'h23,0,0, 4'd4, cMR, 0);
      add(6'h23,0,0, 4'd4, cMR, 0);
      add(6'h23,0,1, 4'd4, cMR, 0);
      add(6'h23,0,1, 4'd5, cWB, 0);
    end
    run_table("perf");
    chk("perf.instr_count", instr_count, 32'd3);
    chk("perf.stall_count", stall_count, 32'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
